// File: rtl/bali_cpu.sv
// Single-cycle bytecode core: executes one instruction per rising edge against a
// 32-bit operand stack and presents the next fetch address on program_counter.
module bali_cpu #(
  parameter int STACK_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  op_code,
  input  logic [7:0]  arg1,
  input  logic [7:0]  arg2,
  output logic [7:0]  program_counter,
  output logic [31:0] stack_top,
  output logic        stack_error
);

  localparam int AW = $clog2(STACK_DEPTH);
  localparam int DW = AW + 1;
  localparam logic [DW-1:0] FULL = DW'(STACK_DEPTH);

  logic [31:0]   stack [STACK_DEPTH];
  logic [DW-1:0] depth, depth_nxt, base;
  logic [1:0]    n_pop, n_push;
  logic [31:0]   v0, v1, p0, p1;
  logic [7:0]    pc_nxt;
  logic          wr0, wr1, under, over;

  function automatic logic cmp(input logic [2:0] c, input logic signed [31:0] x,
                               input logic signed [31:0] y);
    case (c)
      3'd0:    cmp = (x == y);
      3'd1:    cmp = (x != y);
      3'd2:    cmp = (x < y);
      3'd3:    cmp = (x >= y);
      3'd4:    cmp = (x > y);
      3'd5:    cmp = (x <= y);
      default: cmp = 1'b0;
    endcase
  endfunction

  // v0 is the top entry, v1 the one beneath it; missing entries read as 0.
  assign v0 = (depth != '0) ? stack[AW'(depth - DW'(1))] : 32'd0;
  assign v1 = (depth > DW'(1)) ? stack[AW'(depth - DW'(2))] : 32'd0;
  assign stack_top = v0;

  always_comb begin
    n_pop  = 2'd0;
    n_push = 2'd0;
    p0     = 32'd0;
    p1     = 32'd0;
    pc_nxt = program_counter + 8'd1;
    case (op_code) inside
      [8'h02:8'h08]: begin n_push = 2'd1; p0 = {24'd0, op_code} - 32'd3; end
      8'h10: begin
        n_push = 2'd1;
        p0     = {{24{arg1[7]}}, arg1};
        pc_nxt = program_counter + 8'd2;
      end
      8'h11: begin
        n_push = 2'd1;
        p0     = {{16{arg1[7]}}, arg1, arg2};
        pc_nxt = program_counter + 8'd3;
      end
      8'h57: n_pop = 2'd1;
      8'h59: begin n_pop = 2'd1; n_push = 2'd2; p0 = v0; p1 = v0; end
      // swap: re-push the old top first so the old second entry ends on top
      8'h5F: begin n_pop = 2'd2; n_push = 2'd2; p0 = v0; p1 = v1; end
      8'h60: begin n_pop = 2'd2; n_push = 2'd1; p0 = v1 + v0; end
      8'h64: begin n_pop = 2'd2; n_push = 2'd1; p0 = v1 - v0; end
      8'h7E: begin n_pop = 2'd2; n_push = 2'd1; p0 = v1 & v0; end
      8'h80: begin n_pop = 2'd2; n_push = 2'd1; p0 = v1 | v0; end
      8'h82: begin n_pop = 2'd2; n_push = 2'd1; p0 = v1 ^ v0; end
      8'h74: begin n_pop = 2'd1; n_push = 2'd1; p0 = 32'd0 - v0; end
      // only the low offset byte matters since PC arithmetic wraps at 8 bits
      [8'h99:8'h9E]: begin
        n_pop  = 2'd1;
        pc_nxt = cmp(3'(op_code - 8'h99), v0, 32'd0) ? program_counter + arg2
                                                     : program_counter + 8'd3;
      end
      [8'h9F:8'hA4]: begin
        n_pop  = 2'd2;
        pc_nxt = cmp(3'(op_code - 8'h9F), v1, v0) ? program_counter + arg2
                                                  : program_counter + 8'd3;
      end
      8'hA7:   pc_nxt = program_counter + arg2;
      default: ;
    endcase
  end

  always_comb begin
    under     = (depth < DW'(n_pop));
    base      = under ? '0 : depth - DW'(n_pop);
    wr0       = (n_push != 2'd0) && (base < FULL);
    wr1       = (n_push == 2'd2) && ((base + DW'(1)) < FULL);
    over      = ((n_push != 2'd0) && !wr0) || ((n_push == 2'd2) && !wr1);
    depth_nxt = base + DW'(wr0) + DW'(wr1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      program_counter <= 8'd0;
      depth           <= '0;
      stack_error     <= 1'b0;
    end else begin
      program_counter <= pc_nxt;
      depth           <= depth_nxt;
      if (under || over) stack_error <= 1'b1;
    end
  end

  // Entry storage needs no reset: depth alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (wr0) stack[AW'(base)] <= p0;
      if (wr1) stack[AW'(base + DW'(1))] <= p1;
    end
  end

endmodule

// File: tb/tb_bali_cpu.sv
// Directed bench for bali_cpu: instructions are driven on the falling edge and
// outputs are checked at the following falling edge.
module tb_bali_cpu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  op_code = 8'h00;
  logic [7:0]  arg1 = 8'h00;
  logic [7:0]  arg2 = 8'h00;
  logic [7:0]  program_counter;
  logic [31:0] stack_top;
  logic        stack_error;
  int          n_chk = 0;
  int          n_pass = 0;

  bali_cpu #(.STACK_DEPTH(16)) dut (
    .clk(clk), .rst(rst), .op_code(op_code), .arg1(arg1), .arg2(arg2),
    .program_counter(program_counter), .stack_top(stack_top), .stack_error(stack_error)
  );

  always #5 clk = ~clk;

  // Called at a falling edge; returns at the next falling edge after one execute.
  task automatic step(input logic [7:0] op, input logic [7:0] a1 = 8'h00,
                      input logic [7:0] a2 = 8'h00);
    op_code = op; arg1 = a1; arg2 = a2;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; op_code = 8'h00; arg1 = 8'h00; arg2 = 8'h00;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic expect_state(input string name, input logic [7:0] pc,
                              input logic [31:0] top, input logic err);
    n_chk++;
    if (program_counter !== pc) $display("FAIL %s pc got %0h want %0h", name, program_counter, pc);
    else n_pass++;
    n_chk++;
    if (stack_top !== top) $display("FAIL %s top got %0h want %0h", name, stack_top, top);
    else n_pass++;
    n_chk++;
    if (stack_error !== err) $display("FAIL %s err got %0b want %0b", name, stack_error, err);
    else n_pass++;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    expect_state("reset_async", 8'h00, 32'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_nop_wrap();
    for (int i = 0; i < 256; i++) begin
      step(8'h00);
      n_chk++;
      if (program_counter !== 8'(i + 1)) $display("FAIL nop_pc got %0h want %0h", program_counter, 8'(i + 1));
      else n_pass++;
    end
    expect_state("nop_wrap_end", 8'h00, 32'd0, 1'b0);
    step(8'hFF);
    expect_state("undef_opcode", 8'h01, 32'd0, 1'b0);
  endtask

  task automatic test_alu();
    do_reset();
    step(8'h05); step(8'h06); step(8'h60);
    expect_state("iadd", 8'h03, 32'd5, 1'b0);
    step(8'h10, 8'hFE); step(8'h64);
    expect_state("isub", 8'h06, 32'd7, 1'b0);
    step(8'h10, 8'h0C); step(8'h10, 8'h0A); step(8'h7E);
    expect_state("iand", 8'h0B, 32'd8, 1'b0);
    step(8'h10, 8'h03); step(8'h80);
    expect_state("ior", 8'h0E, 32'h0B, 1'b0);
    step(8'h10, 8'h0F); step(8'h82);
    expect_state("ixor", 8'h11, 32'h04, 1'b0);
    step(8'h74);
    expect_state("ineg", 8'h12, 32'hFFFF_FFFC, 1'b0);
    step(8'h11, 8'h80, 8'h01);
    expect_state("sipush", 8'h15, 32'hFFFF_8001, 1'b0);
    step(8'h59); step(8'h60);
    expect_state("dup_iadd", 8'h17, 32'hFFFF_0002, 1'b0);
    step(8'h04); step(8'h05); step(8'h5F);
    expect_state("swap", 8'h1A, 32'd1, 1'b0);
    step(8'h57);
    expect_state("swap_pop", 8'h1B, 32'd2, 1'b0);
  endtask

  task automatic test_goto();
    do_reset();
    for (int i = 0; i < 4; i++) step(8'h00);
    step(8'hA7, 8'h00, 8'h10);
    expect_state("goto_fwd", 8'h14, 32'd0, 1'b0);
    step(8'hA7, 8'hFF, 8'hF0);
    expect_state("goto_back", 8'h04, 32'd0, 1'b0);
    step(8'hA7, 8'h00, 8'h10);
    expect_state("goto_loop", 8'h14, 32'd0, 1'b0);
  endtask

  task automatic test_branch();
    do_reset();
    step(8'h03); step(8'h99, 8'h00, 8'h08);
    expect_state("ifeq_taken", 8'h09, 32'd0, 1'b0);
    do_reset();
    step(8'h04); step(8'h99, 8'h00, 8'h08);
    expect_state("ifeq_not", 8'h04, 32'd0, 1'b0);
    do_reset();
    step(8'h10, 8'hFF); step(8'h9B, 8'h00, 8'h08);
    expect_state("iflt_taken", 8'h0A, 32'd0, 1'b0);
    do_reset();
    step(8'h10, 8'hFF); step(8'h9D, 8'h00, 8'h08);
    expect_state("ifgt_not", 8'h05, 32'd0, 1'b0);
  endtask

  task automatic test_icmp();
    do_reset();
    step(8'h06); step(8'h08); step(8'hA1, 8'h00, 8'h06);
    expect_state("icmplt_taken", 8'h08, 32'd0, 1'b0);
    do_reset();
    step(8'h08); step(8'h06); step(8'hA1, 8'h00, 8'h06);
    expect_state("icmplt_not", 8'h05, 32'd0, 1'b0);
  endtask

  task automatic test_underflow();
    do_reset();
    step(8'h57);
    expect_state("underflow_pop", 8'h01, 32'd0, 1'b1);
    step(8'h07);
    expect_state("error_sticky", 8'h02, 32'd4, 1'b1);
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 1; i <= 16; i++) step(8'h10, 8'(i));
    expect_state("stack_full", 8'h20, 32'd16, 1'b0);
    step(8'h10, 8'd17);
    expect_state("overflow", 8'h22, 32'd16, 1'b1);
    step(8'h60);
    expect_state("after_overflow_iadd", 8'h23, 32'd31, 1'b1);
  endtask

  task automatic test_reset_mid();
    #2 rst = 1'b1;
    #1;
    expect_state("reset_mid", 8'h00, 32'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    step(8'h04);
    expect_state("after_reset", 8'h01, 32'd1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_nop_wrap();
    test_alu();
    test_goto();
    test_branch();
    test_icmp();
    test_underflow();
    test_overflow();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
